i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

Serializes the DSP's stereo output samples (signed 16-bit left/right) onto a standard Philips I2S link for an external audio DAC. Sits downstream of the DSP sample output: the DSP presents a sample pair with a one-cycle valid strobe, and this block buffers one pair and shifts it out MSB-first. It generates bit clock and word select from the system clock and reports underrun and overrun.

## Interface
- DIV_HALF, 8: system clocks per bclk half-period; must be ≥1; bclk = clock/(2·DIV_HALF); frame rate = clock/(64·DIV_HALF).
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_l  in  16  signed left sample (from DSP dac_out_l).
- sample_r  in  16  signed right sample (from DSP dac_out_r).
- sample_valid  in  1  one-cycle strobe: sample_l/sample_r are valid this cycle.
- i2s_bclk  out  1  bit clock, registered.
- i2s_lrclk  out  1  word select, 0 = left, 1 = right, registered.
- i2s_sdata  out  1  serial data, MSB first, registered.
- frame_start  out  1  one-cycle pulse when a new frame is loaded.
- underrun  out  1  one-cycle pulse: frame loaded with no new sample (last pair repeated).
- overrun  out  1  one-cycle pulse: an unsent pending pair was overwritten.

## Operation
- Holding register pend_l/pend_r plus pend_full flag; 32-bit shift register shreg; last-pair register for repeat.
- Divider div_cnt counts 0..DIV_HALF-1; on reaching DIV_HALF-1 it wraps to 0 and i2s_bclk toggles.
- Frame = 32 slots (k = 0..31), one bclk period each; a slot begins on a bclk falling toggle. Slot counter wraps 31→0.
- Slot k: i2s_sdata = word bit (31-k), word = {L[15:0], R[15:0]}; i2s_lrclk = 1 for k in 15..30, else 0 (changes one slot before each channel's MSB, per I2S).
- Load (on the falling toggle entering slot 0): if pend_full, shreg ← {pend_l, pend_r}, last ← pend, pend_full ← 0; else shreg ← {last_l, last_r} and underrun pulses. frame_start pulses on every load. The load cycle's i2s_sdata = bit 31 of the newly loaded word.
- Capture: sample_valid with pend_full=1 and not a load cycle → overwrite pend, overrun pulses. sample_valid otherwise → pend ← sample, pend_full ← 1.
- Simultaneous sample_valid and load: load uses the pend contents from before the edge (no bypass); the new sample goes into pend, pend_full = 1; no overrun. If pend was empty, underrun still pulses.
- Other slot boundaries: shreg shifts left one bit.

## Timing
- Reset values: i2s_bclk 0, i2s_lrclk 0, i2s_sdata 0, frame_start/underrun/overrun 0, div_cnt 0, slot = 31, shreg 0, last 0, pend_full 0.
- After reset, bclk rises at edge DIV_HALF and falls at edge 2·DIV_HALF; that falling edge is the first load (slot 0).
- Reset mid-frame aborts the frame immediately; outputs take reset values on the next edge; the pending sample is discarded.
- Sample latency: sample_valid at cycle t sets pend_full at t+1 and is emitted from the next load at or after t+1.
- Outputs change only on bclk falling edges (sdata, lrclk) so the DAC samples stably on rising edges; the per-slot sdata hold time is 2·DIV_HALF clocks.
- With DIV_HALF=1, bclk toggles every cycle; all rules above still hold.

## Test plan
- Reset then idle, DIV_HALF=2: first load at clock 4 with underrun=1 and frame_start=1; sdata all 0 for 32 slots; lrclk high for slots 15..30; load every 128 clocks thereafter.
- Single pair L=16'h8001, R=16'h7FFE before the first load: serial stream 1000…0001 then 0111…1110; lrclk falls one slot before the L MSB; no underrun.
- Sample once, then none: next frame repeats 8001/7FFE and underrun pulses exactly once per frame.
- Two sample_valid strobes (A, then B) in one frame: overrun pulses once; B is transmitted and A never appears.
- sample_valid on the exact load cycle with pend empty: underrun pulses; that sample is sent in the following frame; overrun stays 0.
- Assert reset during slot 20: on the next edge bclk/lrclk/sdata = 0 and pend_full = 0; the first load after release follows the same timing as after power-up reset.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: buffers one stereo pair (clock, reset, sample_l/r, sample_valid in) and serializes it as Philips I2S (i2s_bclk, i2s_lrclk, i2s_sdata) with frame_start/underrun/overrun pulses
module i2s_dac_tx #(
  parameter int DIV_HALF = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun
);
  localparam int W = DIV_HALF > 1 ? $clog2(DIV_HALF) : 1;
  logic [W-1:0] div_cnt;
  logic [4:0]   slot, nslot;
  logic [31:0]  shreg, pend, last, word;
  logic         pend_full, tick, fall, load;
  assign tick  = div_cnt == W'(DIV_HALF - 1);
  assign fall  = tick && i2s_bclk;
  assign load  = fall && slot == 5'd31;
  assign nslot = slot + 5'd1;
  assign word  = pend_full ? pend : last;
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt     <= '0;
      slot        <= 5'd31;
      shreg       <= '0;
      pend        <= '0;
      last        <= '0;
      pend_full   <= 1'b0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        slot      <= nslot;
        i2s_lrclk <= nslot >= 5'd15 && nslot <= 5'd30;
        shreg     <= load ? word : shreg << 1;
        i2s_sdata <= load ? word[31] : shreg[30];
      end
      frame_start <= load;
      underrun    <= load && !pend_full;
      overrun     <= sample_valid && pend_full && !load;
      // a load consumes the pre-edge pend; a same-cycle sample refills it
      if (sample_valid) pend <= {sample_l, sample_r};
      pend_full <= sample_valid || (pend_full && !load);
      if (load && pend_full) last <= pend;
    end
  end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized scoreboard bench for i2s_dac_tx
module tb_i2s_dac_tx;
  localparam int DH = 2;
  localparam int FR = 64 * DH;
  localparam int L0 = 2 * DH;
  logic clock = 0, reset = 1, sample_valid = 0;
  logic [15:0] sample_l = 0, sample_r = 0;
  logic i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun;
  i2s_dac_tx #(.DIV_HALF(DH)) dut (
    .clock(clock), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underrun(underrun), .overrun(overrun)
  );
  always #5 clock = ~clock;
  typedef struct {logic [31:0] w; bit ur; int cyc;} frame_t;
  frame_t q[$];
  int oq[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int e = 0;
  bit pf = 0;
  logic [31:0] pend = 0, last = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask
  function automatic bit is_load(input int n);
    return n >= L0 && (n - L0) % FR == 0;
  endfunction
  // reference model: per-edge bookkeeping of the one-pair buffer and the frame schedule
  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r);
    bit ld;
    sample_valid = v;
    sample_l = l;
    sample_r = r;
    e++;
    ld = is_load(e);
    if (ld) begin
      q.push_back('{w: pf ? pend : last, ur: !pf, cyc: e});
      if (pf) last = pend;
      pf = 0;
    end
    if (v) begin
      if (pf && !ld) oq.push_back(e);
      pend = {l, r};
      pf = 1;
    end
    @(posedge clock);
    #1;
    sample_valid = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0);
  endtask
  task automatic do_reset();
    chk("frames_outstanding", q.size(), 0);
    chk("overruns_outstanding", oq.size(), 0);
    reset = 1;
    sample_valid = 0;
    @(posedge clock);
    #1;
    chk("reset_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun}, 0);
    q.delete();
    oq.delete();
    e = 0;
    pf = 0;
    pend = 0;
    last = 0;
    reset = 0;
  endtask
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;
  // monitor: pops expected frames on frame_start and collects the 32 serial slots
  bit active = 0;
  int mcnt = 0, k;
  logic [31:0] got;
  frame_t cur;
  always @(negedge clock) begin
    if (reset) active = 0;
    else begin
      chk("bclk", i2s_bclk, (cyc / DH) % 2);
      if (overrun) begin
        if (oq.size() == 0) fail("overrun_unexpected");
        else chk("overrun_cycle", cyc, oq.pop_front());
      end
      if (underrun && !frame_start) fail("underrun_without_load");
      if (frame_start) begin
        if (q.size() == 0) fail("load_unexpected");
        else begin
          cur = q.pop_front();
          chk("load_cycle", cyc, cur.cyc);
          chk("underrun", underrun, cur.ur);
        end
        active = 1;
        mcnt = 0;
      end
      if (active && mcnt % (2 * DH) == 0) begin
        k = mcnt / (2 * DH);
        got[31-k] = i2s_sdata;
        chk("lrclk", i2s_lrclk, k >= 15 && k <= 30);
        if (k == 31) begin
          chk("word", got, cur.w);
          active = 0;
        end
      end
      if (active) mcnt++;
    end
  end
  initial begin
    do_reset();
    idle(140);
    do_reset();
    step(1, 16'h8001, 16'h7FFE);
    idle(270);
    while ((e - L0) % FR != 10) idle(1);
    step(1, 16'hAAAA, 16'h1111);
    idle(7);
    step(1, 16'h5555, 16'h2222);
    while (!is_load(e + 1)) idle(1);
    idle(1);
    while (!is_load(e + 1)) idle(1);
    step(1, 16'hC3C3, 16'h3C3C);
    idle(2 * FR);
    for (int i = 0; i < 2000; i++)
      if ($urandom_range(0, 59) == 0) step(1, 16'($urandom), 16'($urandom));
      else idle(1);
    while ((e - L0) % FR != 40) idle(1);
    step(1, 16'h1234, 16'h5678);
    while ((e - L0) % FR != 81) idle(1);
    do_reset();
    idle(FR + 20);
    while ((e - L0) % FR != FR - 2) idle(1);
    chk("frames_left", q.size(), 0);
    chk("overruns_left", oq.size(), 0);
    chk("monitor_idle", active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
